// File: rtl/axistream_snooper_pkg.sv
// Shared definitions for the AXI-Stream snooper.
// Packet-memory geometry, width helper and FSM state type.
package axistream_snooper_pkg;

    localparam int PKT_MEM_BYTES      = 2048;
    localparam int PKT_MEM_DATA_WIDTH = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int PKT_MEM_WORDS =
        PKT_MEM_BYTES / (PKT_MEM_DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RECV,
        S_TRUNC,
        S_DROP,
        S_DONE
    } snoop_state_t;

endpackage

// File: rtl/axistream_snooper_keep_popcount.sv
// TKEEP to valid-byte count conversion.
// Purely combinational; shared with the forwarder.
module keep_popcount #(
    parameter int KEEP_WIDTH = 8,
    parameter int INC_WIDTH  = 4
) (
    input  logic [KEEP_WIDTH-1:0] keep,
    output logic [INC_WIDTH-1:0]  count
);

    // Sum every set byte-enable bit.
    always_comb begin
        count = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            count = count + INC_WIDTH'(keep[i]);
        end
    end

endmodule

// File: rtl/axistream_snooper.sv
// Passive AXI-Stream tap feeding a packetfilter_core buffer.
// Claims a buffer, writes one flit per word, ends with sn_done.
module axistream_snooper
    import axistream_snooper_pkg::*;
#(
    parameter int SN_DATA_WIDTH = PKT_MEM_DATA_WIDTH,
    parameter int SN_ADDR_WIDTH = clog2(PKT_MEM_WORDS),
    parameter int INC_WIDTH     = clog2(SN_DATA_WIDTH / 8) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SN_DATA_WIDTH-1:0]   snoop_TDATA,
    input  logic [SN_DATA_WIDTH/8-1:0] snoop_TKEEP,
    input  logic                       snoop_TVALID,
    input  logic                       snoop_TREADY,
    input  logic                       snoop_TLAST,
    output logic [SN_ADDR_WIDTH-1:0]   sn_addr,
    output logic [SN_DATA_WIDTH-1:0]   sn_wr_data,
    output logic                       sn_wr_en,
    output logic [INC_WIDTH-1:0]       sn_byte_inc,
    output logic                       sn_done,
    input  logic                       rdy_for_sn,
    output logic                       rdy_for_sn_ack
);

    snoop_state_t state;
    snoop_state_t state_n;

    logic [SN_ADDR_WIDTH-1:0] addr;
    logic [SN_ADDR_WIDTH-1:0] addr_n;
    logic                     in_pkt;

    logic [SN_ADDR_WIDTH-1:0] out_addr_n;
    logic [SN_DATA_WIDTH-1:0] data_n;
    logic [INC_WIDTH-1:0]     inc_n;
    logic                     wr_en_n;
    logic                     done_n;
    logic                     ack_n;
    logic                     take;

    logic [INC_WIDTH-1:0] byte_count;
    logic                 flit;
    logic                 start;
    logic                 has_data;
    logic                 last_addr;

    assign flit      = snoop_TVALID & snoop_TREADY;
    assign start     = flit & ~in_pkt;
    assign has_data  = |snoop_TKEEP;
    assign last_addr = (addr == {SN_ADDR_WIDTH{1'b1}});

    keep_popcount #(
        .KEEP_WIDTH (SN_DATA_WIDTH / 8),
        .INC_WIDTH  (INC_WIDTH)
    ) u_popcount (
        .keep  (snoop_TKEEP),
        .count (byte_count)
    );

    // Next state, next address and the values the output registers take.
    always_comb begin
        state_n    = state;
        addr_n     = addr;
        wr_en_n    = 1'b0;
        done_n     = 1'b0;
        ack_n      = 1'b0;
        out_addr_n = '0;
        data_n     = '0;
        inc_n      = '0;
        take       = 1'b0;

        unique case (state)
            S_IDLE: begin
                addr_n = '0;
                if (start) begin
                    state_n = snoop_TLAST ? S_IDLE : S_DROP;
                end else if (rdy_for_sn && !in_pkt) begin
                    ack_n   = 1'b1;
                    state_n = S_ARMED;
                end
            end
            S_ARMED: take = start;
            S_RECV:  take = flit;
            S_TRUNC: begin
                if (flit && snoop_TLAST) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_DROP: begin
                if (flit && snoop_TLAST) begin
                    state_n = S_IDLE;
                end
            end
            S_DONE: begin
                addr_n  = '0;
                // A start flit here arrives too early to be captured.
                state_n = (start && !snoop_TLAST) ? S_DROP : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        if (take) begin
            if (has_data) begin
                wr_en_n    = 1'b1;
                out_addr_n = addr;
                data_n     = snoop_TDATA;
                inc_n      = byte_count;
                addr_n     = addr + SN_ADDR_WIDTH'(1);
            end
            if (snoop_TLAST) begin
                done_n  = 1'b1;
                state_n = S_DONE;
            end else if (has_data && last_addr) begin
                state_n = S_TRUNC;
            end else begin
                state_n = S_RECV;
            end
        end
    end

    // State, address counter and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            addr           <= '0;
            sn_addr        <= '0;
            sn_wr_data     <= '0;
            sn_wr_en       <= 1'b0;
            sn_byte_inc    <= '0;
            sn_done        <= 1'b0;
            rdy_for_sn_ack <= 1'b0;
        end else begin
            state          <= state_n;
            addr           <= addr_n;
            sn_addr        <= out_addr_n;
            sn_wr_data     <= data_n;
            sn_wr_en       <= wr_en_n;
            sn_byte_inc    <= inc_n;
            sn_done        <= done_n;
            rdy_for_sn_ack <= ack_n;
        end
    end

    // Packet boundary tracking, independent of the capture FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_pkt <= 1'b0;
        end else if (flit) begin
            in_pkt <= ~snoop_TLAST;
        end
    end

endmodule

// File: tb/tb_axistream_snooper.sv
// Self-checking bench for axistream_snooper.
// Directed scenarios plus random traffic against a packet-level model.
module tb_axistream_snooper;

    logic        clk;
    logic        rst;
    logic [63:0] snoop_TDATA;
    logic [7:0]  snoop_TKEEP;
    logic        snoop_TVALID;
    logic        snoop_TREADY;
    logic        snoop_TLAST;
    logic [7:0]  sn_addr;
    logic [63:0] sn_wr_data;
    logic        sn_wr_en;
    logic [3:0]  sn_byte_inc;
    logic        sn_done;
    logic        rdy_for_sn;
    logic        rdy_for_sn_ack;

    int checks;
    int failures;
    int wr_seen;
    int ack_seen;

    // Model: buffer ownership modes and packet position.
    localparam int M_FREE = 0;
    localparam int M_CAPT = 1;
    localparam int M_DROP = 2;
    localparam int M_TRNC = 3;
    localparam int WORDS  = 256;

    int   m_mode;
    int   m_words;
    bit   m_in_pkt;
    bit   m_settle;

    logic [7:0]  exp_addr;
    logic [63:0] exp_data;
    logic        exp_wr_en;
    logic [3:0]  exp_inc;
    logic        exp_done;
    logic        exp_ack;

    axistream_snooper dut (
        .clk            (clk),
        .rst            (rst),
        .snoop_TDATA    (snoop_TDATA),
        .snoop_TKEEP    (snoop_TKEEP),
        .snoop_TVALID   (snoop_TVALID),
        .snoop_TREADY   (snoop_TREADY),
        .snoop_TLAST    (snoop_TLAST),
        .sn_addr        (sn_addr),
        .sn_wr_data     (sn_wr_data),
        .sn_wr_en       (sn_wr_en),
        .sn_byte_inc    (sn_byte_inc),
        .sn_done        (sn_done),
        .rdy_for_sn     (rdy_for_sn),
        .rdy_for_sn_ack (rdy_for_sn_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs after the coming edge, from the current inputs.
    task automatic model_step();
        bit flit;
        bit start;
        exp_addr  = '0;
        exp_data  = '0;
        exp_wr_en = 1'b0;
        exp_inc   = '0;
        exp_done  = 1'b0;
        exp_ack   = 1'b0;
        if (rst) begin
            m_mode   = M_FREE;
            m_words  = 0;
            m_in_pkt = 0;
            m_settle = 0;
            return;
        end
        flit  = snoop_TVALID && snoop_TREADY;
        start = flit && !m_in_pkt;
        case (m_mode)
            M_FREE: begin
                if (start) begin
                    m_mode   = snoop_TLAST ? M_FREE : M_DROP;
                    m_settle = 0;
                end else if (m_settle) begin
                    m_settle = 0;
                end else if (rdy_for_sn && !m_in_pkt) begin
                    exp_ack = 1'b1;
                    m_mode  = M_CAPT;
                    m_words = 0;
                end
            end
            M_CAPT: begin
                if (flit) begin
                    if (snoop_TKEEP != 0) begin
                        exp_wr_en = 1'b1;
                        exp_addr  = 8'(m_words);
                        exp_data  = snoop_TDATA;
                        exp_inc   = 4'($countones(snoop_TKEEP));
                        m_words++;
                    end
                    if (snoop_TLAST) begin
                        exp_done = 1'b1;
                        m_mode   = M_FREE;
                        m_settle = 1;
                    end else if (m_words == WORDS) begin
                        m_mode = M_TRNC;
                    end
                end
            end
            M_TRNC: begin
                if (flit && snoop_TLAST) begin
                    exp_done = 1'b1;
                    m_mode   = M_FREE;
                end
            end
            default: begin
                if (flit && snoop_TLAST) m_mode = M_FREE;
            end
        endcase
        if (flit) m_in_pkt = !snoop_TLAST;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("wr_en", sn_wr_en, exp_wr_en);
        chk("done", sn_done, exp_done);
        chk("ack", rdy_for_sn_ack, exp_ack);
        chk("addr", sn_addr, exp_addr);
        chk("data", sn_wr_data, exp_data);
        chk("byte_inc", sn_byte_inc, exp_inc);
        if (sn_wr_en) wr_seen++;
        if (rdy_for_sn_ack) ack_seen++;
    endtask

    task automatic drive_flit(input logic last, input logic [7:0] keep);
        snoop_TVALID = 1'b1;
        snoop_TREADY = 1'b1;
        snoop_TLAST  = last;
        snoop_TKEEP  = keep;
        snoop_TDATA  = {$urandom, $urandom};
        cycle();
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            snoop_TVALID = 1'b1;
            snoop_TREADY = 1'b0;
            snoop_TLAST  = 1'($urandom);
            snoop_TKEEP  = 8'($urandom);
            snoop_TDATA  = {$urandom, $urandom};
            cycle();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            snoop_TVALID = 1'b0;
            snoop_TREADY = 1'($urandom);
            snoop_TLAST  = 1'($urandom);
            snoop_TKEEP  = 8'($urandom);
            snoop_TDATA  = {$urandom, $urandom};
            cycle();
        end
    endtask

    task automatic send_pkt(input int n, input logic [7:0] last_keep);
        for (int i = 0; i < n; i++) begin
            drive_flit(i == n - 1, (i == n - 1) ? last_keep : 8'hFF);
        end
    endtask

    function automatic logic [7:0] keep_of(input int k);
        logic [7:0] ones;
        ones = 8'hFF;
        return (k == 0) ? 8'h00 : ones << (8 - k);
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        wr_seen  = 0;
        ack_seen = 0;
        rst          = 1'b1;
        rdy_for_sn   = 1'b0;
        snoop_TVALID = 1'b0;
        snoop_TREADY = 1'b0;
        snoop_TLAST  = 1'b0;
        snoop_TKEEP  = '0;
        snoop_TDATA  = '0;

        // Reset state.
        idle(2);
        rst = 1'b0;

        // Armed 3-flit packet, tail keep F0.
        rdy_for_sn = 1'b1;
        ack_seen   = 0;
        idle(3);
        chk("t1_ack_count", 64'(ack_seen), 64'd1);
        wr_seen = 0;
        send_pkt(3, 8'hF0);
        chk("t1_writes", 64'(wr_seen), 64'd3);
        idle(1);

        // No buffer at packet start; ready raised mid-packet.
        rdy_for_sn = 1'b0;
        idle(3);
        wr_seen  = 0;
        ack_seen = 0;
        drive_flit(1'b0, 8'hFF);
        drive_flit(1'b0, 8'hFF);
        rdy_for_sn = 1'b1;
        drive_flit(1'b0, 8'hFF);
        drive_flit(1'b1, 8'hFF);
        chk("t2_no_writes", 64'(wr_seen), 64'd0);
        chk("t2_no_ack_in_pkt", 64'(ack_seen), 64'd0);
        idle(3);
        chk("t2_ack_after", 64'(ack_seen), 64'd1);
        send_pkt(2, 8'hFF);
        idle(3);

        // Backpressure inside a packet.
        wr_seen = 0;
        drive_flit(1'b0, 8'hFF);
        drive_flit(1'b0, 8'hFF);
        stall(3);
        drive_flit(1'b0, 8'hFF);
        drive_flit(1'b1, 8'h80);
        chk("t3_writes", 64'(wr_seen), 64'd4);
        idle(3);

        // Oversize packet truncated at the last word.
        wr_seen = 0;
        send_pkt(300, 8'hC0);
        chk("t4_writes", 64'(wr_seen), 64'd256);
        idle(3);

        // Reset after flit 2 of 5; tail captured as a new packet.
        drive_flit(1'b0, 8'hFF);
        drive_flit(1'b0, 8'hFF);
        rst          = 1'b1;
        snoop_TVALID = 1'b0;
        cycle();
        rst = 1'b0;
        idle(2);
        wr_seen = 0;
        send_pkt(3, 8'hFF);
        chk("t5_tail_writes", 64'(wr_seen), 64'd3);
        idle(3);

        // Back-to-back packets, then one after a 2-cycle gap.
        wr_seen = 0;
        send_pkt(3, 8'hFF);
        send_pkt(3, 8'hFF);
        chk("t6_second_dropped", 64'(wr_seen), 64'd3);
        idle(2);
        send_pkt(3, 8'hE0);
        chk("t6_third_captured", 64'(wr_seen), 64'd6);
        idle(3);

        // Empty flits mid-packet and at the tail; single-flit packet.
        drive_flit(1'b0, 8'hFF);
        drive_flit(1'b0, 8'h00);
        drive_flit(1'b0, 8'hF8);
        drive_flit(1'b1, 8'h00);
        idle(3);
        send_pkt(1, 8'hE0);
        idle(3);

        // Random traffic.
        for (int p = 0; p < 80; p++) begin
            int n;
            rdy_for_sn = ($urandom_range(0, 3) != 0);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 4) == 0) stall($urandom_range(1, 2));
                drive_flit(i == n - 1, keep_of($urandom_range(0, 8)));
            end
            idle($urandom_range(0, 3));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
